alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU.
- Captures the ALU's 64-bit `data_out` plus `z_flag`/`carry_flag` and drives the 32-bit register-file write port.
- MUL results are split: low word goes to rd, high word to rd+1, over two cycles, with upstream backpressure.
- Also holds the architectural Z/C flag register and a retired-write counter.

Parameters:
- DATA_W, 32, register/write-port data width; ALU result width is 2*DATA_W.
- REG_ADDR_W, 5, register-file address width.
- MUL_OP, 4'b0010, opcode value that triggers the two-word write.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of any pending write.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  4  opcode that produced the result.
- in_rd  input  REG_ADDR_W  destination register.
- in_wb_en  input  1  result is to be written (0 = flags-only).
- in_result  input  2*DATA_W  ALU data_out.
- in_z_flag  input  1  ALU z_flag.
- in_carry_flag  input  1  ALU carry_flag.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  REG_ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- flag_z  output  1  architectural zero flag.
- flag_c  output  1  architectural carry flag.
- wb_count  output  32  number of performed register writes, wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, capture registers=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - flag_z=0, flag_c=0, wb_count=0.
  - in_ready=1 after reset release.
  - Reset mid-MUL drops the pending HI write.
- States: IDLE, WR_LO, WR_HI.
- Handshake:
  - Accept occurs when in_valid && in_ready && !flush.
  - in_ready = !flush && !(state==WR_LO && captured opcode==MUL_OP).
- Transitions:
  - IDLE: accept -> WR_LO; otherwise stay.
  - WR_LO:
    - Captured op is MUL -> WR_HI (in_ready=0).
    - Else: accept -> WR_LO with the new capture; otherwise -> IDLE.
  - WR_HI: accept -> WR_LO; otherwise -> IDLE.
- Throughput: back-to-back non-MUL ops at 1 per cycle. A MUL occupies 2 cycles, giving 1 bubble upstream.
- Latency: one cycle from accept to the WR_LO write.
- Write outputs (combinational from capture regs):
  - WR_LO: wr_addr=rd, wr_data=result[DATA_W-1:0].
  - WR_HI: wr_addr=(rd+1) mod 2^REG_ADDR_W, wr_data=result[2*DATA_W-1:DATA_W].
- wr_en=1 only when all of the following hold:
  - state is WR_LO or WR_HI;
  - captured wb_en=1;
  - wr_addr!=0 (r0 is never written);
  - flush=0.
- Suppressed writes still consume their cycle, so rd=31 MUL still takes the WR_HI cycle with wr_en=0.
- Outside write cycles, wr_addr/wr_data hold their last value and wr_en=0.
- wb_count increments by 1 on every cycle with wr_en=1.
- Flag register (updated on the WR_LO cycle only, if flush=0):
  - flag_z <= captured z for all opcodes (the 64-bit z for MUL).
  - flag_c <= captured carry only for ADD(0000), SUB(0001), INC(1010), DEC(1011); held for all other opcodes.
  - Flags update regardless of wb_en.
- Flush:
  - Forces wr_en=0 and in_ready=0 in the same cycle.
  - No flag or counter update.
  - Next state=IDLE, including a pending WR_HI.
  - Flush has priority over an accept in the same cycle.

Test Plan:
- ADD result 0x0000_0000_0000_001E, rd=3, z=0, c=0 -> next cycle wr_en=1, wr_addr=3, wr_data=0x1E; flag_z=0, flag_c=0; wb_count=1.
- MUL result 0x0000_FFFE_0001, rd=4 -> cycle 1: r4 <= 0xFFFE0001. Cycle 2: r5 <= 0x00000000, in_ready=0 during cycle 1. Upstream holds in_valid and the next op is accepted in cycle 2.
- Three back-to-back XOR ops (rd=1,2,3) with continuous in_valid -> three consecutive writes, in_ready stays 1; wb_count=3.
- MUL with rd=31, result 0x1_0000_0000 -> r31 <= 0. HI cycle wr_addr=0 with wr_en=0; wb_count increments only once.
- ADD 0xFFFFFFFF+1 (c=1), then AND result 0 (c=0, z=1) -> flag_c=1 stays 1 after AND; flag_z=1.
- MUL accepted, flush asserted in WR_HI -> no HI write, state IDLE next cycle, flags as of the WR_LO cycle. Separately, rst_n low mid-WR_LO -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//
// Writeback stage that sits directly behind the ALU. It captures one ALU
// result per accepted handshake and turns it into register-file writes:
// ordinary ops produce one write, MUL produces two consecutive writes
// (low word to rd, high word to rd+1) and stalls upstream for one cycle.
// The stage also owns the architectural Z/C flag register and a counter
// of performed register writes.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   flush           synchronous discard of any pending write
//   in_valid        ALU result valid
//   in_ready        stage can accept a result this cycle
//   in_opcode       opcode that produced the result
//   in_rd           destination register
//   in_wb_en        result is written (0 = flags-only op)
//   in_result       full 2*DATA_W ALU result
//   in_z_flag       ALU zero flag
//   in_carry_flag   ALU carry flag
//   wr_en           register-file write strobe
//   wr_addr         register-file write address
//   wr_data         register-file write data
//   flag_z, flag_c  architectural zero / carry flags
//   wb_count        number of performed register writes (wraps)
// ---------------------------------------------------------------------------
module alu_writeback #(
    parameter int         DATA_W     = 32,
    parameter int         REG_ADDR_W = 5,
    parameter logic [3:0] MUL_OP     = 4'b0010
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_opcode,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wb_en,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic                  in_z_flag,
    input  logic                  in_carry_flag,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic [31:0]           wb_count
);

    // Opcodes whose carry output is architecturally meaningful.
    localparam logic [3:0] ADD_OP = 4'b0000;
    localparam logic [3:0] SUB_OP = 4'b0001;
    localparam logic [3:0] INC_OP = 4'b1010;
    localparam logic [3:0] DEC_OP = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Capture registers holding the result currently being written back.
    logic [3:0]            cap_opcode;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic                  cap_wb_en;
    logic [2*DATA_W-1:0]   cap_result;
    logic                  cap_z;
    logic                  cap_c;

    // Last address/data shown on the write port, so the port holds its
    // value outside write cycles instead of showing stale capture data.
    logic [REG_ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0]     hold_data;

    logic                  accept;
    logic                  write_cycle;
    logic                  mul_lo;
    logic                  carry_op;
    logic [REG_ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0]     slot_data;

    // Next-state and output decode. The only cycle in which a new result
    // cannot be taken (apart from flush) is the low half of a MUL, because
    // the following cycle is already committed to the high-word write.
    // Flush wins over everything: it blocks the handshake, kills the write
    // strobe and returns the FSM to IDLE, dropping any pending HI write.
    always_comb begin
        next_state  = state;
        mul_lo      = 1'b0;
        in_ready    = 1'b1;
        accept      = 1'b0;
        write_cycle = 1'b0;
        slot_addr   = cap_rd;
        slot_data   = cap_result[DATA_W-1:0];
        wr_addr     = hold_addr;
        wr_data     = hold_data;
        wr_en       = 1'b0;

        mul_lo      = (state == WR_LO) && (cap_opcode == MUL_OP);
        in_ready    = !flush && !mul_lo;
        accept      = in_valid && in_ready;
        write_cycle = (state == WR_LO) || (state == WR_HI);

        if (state == WR_HI) begin
            slot_addr = cap_rd + REG_ADDR_W'(1);
            slot_data = cap_result[2*DATA_W-1:DATA_W];
        end

        if (write_cycle) begin
            wr_addr = slot_addr;
            wr_data = slot_data;
        end

        // r0 is hard-wired; a write aimed at it still uses its cycle.
        wr_en = write_cycle && cap_wb_en && (slot_addr != '0) && !flush;

        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = WR_LO;
                end
            end
            WR_LO: begin
                if (mul_lo) begin
                    next_state = WR_HI;
                end else if (accept) begin
                    next_state = WR_LO;
                end else begin
                    next_state = IDLE;
                end
            end
            WR_HI: begin
                if (accept) begin
                    next_state = WR_LO;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (flush) begin
            next_state = IDLE;
        end
    end

    // Carry is only architecturally updated by the arithmetic ops; logic
    // ops and MUL leave the previous carry in place.
    always_comb begin
        carry_op = 1'b0;
        case (cap_opcode)
            ADD_OP, SUB_OP, INC_OP, DEC_OP: carry_op = 1'b1;
            default:                        carry_op = 1'b0;
        endcase
    end

    // State register and capture registers. A new result is captured on
    // every accepted handshake; the capture stays put while the FSM walks
    // through the LO/HI write cycles of that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_opcode <= '0;
            cap_rd     <= '0;
            cap_wb_en  <= 1'b0;
            cap_result <= '0;
            cap_z      <= 1'b0;
            cap_c      <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_opcode <= in_opcode;
                cap_rd     <= in_rd;
                cap_wb_en  <= in_wb_en;
                cap_result <= in_result;
                cap_z      <= in_z_flag;
                cap_c      <= in_carry_flag;
            end
        end
    end

    // Remember whatever the write port showed during a write cycle, even a
    // suppressed one, so that idle cycles keep presenting the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (write_cycle) begin
            hold_addr <= slot_addr;
            hold_data <= slot_data;
        end
    end

    // Flags retire with the low-word cycle of each result, whether or not
    // the result is actually written. A flushed LO cycle changes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if ((state == WR_LO) && !flush) begin
            flag_z <= cap_z;
            if (carry_op) begin
                flag_c <= cap_c;
            end
        end
    end

    // Count every strobe that actually reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (wr_en) begin
            wb_count <= wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//
// Bench for alu_writeback: a table of hand-computed per-cycle vectors,
// a reset-during-write sequence, and a randomized run checked against a
// transaction-level model (a queue of pending write slots).
// ---------------------------------------------------------------------------
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic [63:0] in_result;
    logic        in_z_flag;
    logic        in_carry_flag;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flag_z;
    logic        flag_c;
    logic [31:0] wb_count;

    int checks = 0;
    int errors = 0;

    alu_writeback #(
        .DATA_W    (32),
        .REG_ADDR_W(5),
        .MUL_OP    (4'b0010)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_wb_en     (in_wb_en),
        .in_result    (in_result),
        .in_z_flag    (in_z_flag),
        .in_carry_flag(in_carry_flag),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row: inputs driven for a cycle and the outputs expected
    // during that same cycle (before the next rising edge).
    typedef struct {
        logic        valid;
        logic        fl;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wb;
        logic [63:0] res;
        logic        z;
        logic        c;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_fz;
        logic        e_fc;
        logic [31:0] e_cnt;
    } vec_t;

    // A pending register-file write slot in the reference model.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        wb;
        logic        is_lo;
        logic        is_mul;
        logic [3:0]  op;
        logic        z;
        logic        c;
    } slot_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b1010;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mkRow(logic valid, logic fl, logic [3:0] op, logic [4:0] rd,
                                   logic wb, logic [63:0] res, logic z, logic c,
                                   logic e_en, logic [4:0] e_addr, logic [31:0] e_data,
                                   logic e_ready, logic e_fz, logic e_fc, logic [31:0] e_cnt);
        vec_t v;
        v.valid = valid; v.fl = fl; v.op = op; v.rd = rd; v.wb = wb;
        v.res = res; v.z = z; v.c = c;
        v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data; v.e_ready = e_ready;
        v.e_fz = e_fz; v.e_fc = e_fc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic fl, input logic [3:0] op,
                                 input logic [4:0] rd, input logic wb, input logic [63:0] res,
                                 input logic z, input logic c);
        @(negedge clk);
        in_valid      = valid;
        flush         = fl;
        in_opcode     = op;
        in_rd         = rd;
        in_wb_en      = wb;
        in_result     = res;
        in_z_flag     = z;
        in_carry_flag = c;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; in_opcode = '0; in_rd = '0;
        in_wb_en = 1'b0; in_result = '0; in_z_flag = 1'b0; in_carry_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic carryOp(logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b1010) || (op == 4'b1011);
    endfunction

    // Reference model state.
    slot_t       q[$];
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic        m_fz;
    logic        m_fc;
    logic [31:0] m_cnt;

    initial begin
        logic        e_en;
        logic        e_ready;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  ops[10];
        slot_t       s;
        slot_t       h;

        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_MUL, OP_AND, OP_XOR, OP_INC, 4'b1011, 4'b0101, 4'b1111};

        // --- Hand-computed vector table -------------------------------------
        //                  vld fl op      rd  wb res                     z  c   en addr   data           rdy fz fc cnt
        vecs[0]  = mkRow(1, 0, OP_ADD, 3,  1, 64'h1E,                 0, 0,  0, 0,  32'h0,          1, 0, 0, 0);
        vecs[1]  = mkRow(1, 0, OP_MUL, 4,  1, 64'h0000_FFFE_0001,     0, 0,  1, 3,  32'h1E,         1, 0, 0, 0);
        vecs[2]  = mkRow(1, 0, OP_XOR, 1,  1, 64'h11,                 0, 0,  1, 4,  32'hFFFE_0001,  0, 0, 0, 1);
        vecs[3]  = mkRow(1, 0, OP_XOR, 1,  1, 64'h11,                 0, 0,  1, 5,  32'h0,          1, 0, 0, 2);
        vecs[4]  = mkRow(1, 0, OP_XOR, 2,  1, 64'h22,                 0, 0,  1, 1,  32'h11,         1, 0, 0, 3);
        vecs[5]  = mkRow(1, 0, OP_XOR, 3,  1, 64'h33,                 0, 0,  1, 2,  32'h22,         1, 0, 0, 4);
        vecs[6]  = mkRow(1, 0, OP_MUL, 31, 1, 64'h1_0000_0000,        0, 0,  1, 3,  32'h33,         1, 0, 0, 5);
        vecs[7]  = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  1, 31, 32'h0,          0, 0, 0, 6);
        vecs[8]  = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 0,  32'h1,          1, 0, 0, 7);
        vecs[9]  = mkRow(1, 0, OP_ADD, 6,  1, 64'h1_0000_0000,        0, 1,  0, 0,  32'h1,          1, 0, 0, 7);
        vecs[10] = mkRow(1, 0, OP_AND, 7,  1, 64'h0,                  1, 0,  1, 6,  32'h0,          1, 0, 0, 7);
        vecs[11] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  1, 7,  32'h0,          1, 0, 1, 8);
        vecs[12] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 7,  32'h0,          1, 1, 1, 9);
        vecs[13] = mkRow(1, 0, OP_MUL, 8,  1, 64'hAAAA_AAAA_5555_5555, 0, 1, 0, 7,  32'h0,          1, 1, 1, 9);
        vecs[14] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  1, 8,  32'h5555_5555,  0, 1, 1, 9);
        vecs[15] = mkRow(1, 1, OP_ADD, 9,  1, 64'h9,                  1, 1,  0, 9,  32'hAAAA_AAAA,  0, 0, 1, 10);
        vecs[16] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 9,  32'hAAAA_AAAA,  1, 0, 1, 10);
        vecs[17] = mkRow(1, 0, OP_SUB, 10, 0, 64'h5,                  1, 1,  0, 9,  32'hAAAA_AAAA,  1, 0, 1, 10);
        vecs[18] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 10, 32'h5,          1, 0, 1, 10);
        vecs[19] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 10, 32'h5,          1, 1, 1, 10);
        vecs[20] = mkRow(1, 0, OP_INC, 11, 1, 64'h7,                  0, 0,  0, 10, 32'h5,          1, 1, 1, 10);
        vecs[21] = mkRow(0, 1, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 11, 32'h7,          0, 1, 1, 10);
        vecs[22] = mkRow(0, 0, OP_ADD, 0,  0, 64'h0,                  0, 0,  0, 11, 32'h7,          1, 1, 1, 10);

        resetDut();
        #1;
        checkOutput("reset wr_en", wr_en, 0);
        checkOutput("reset wr_addr", wr_addr, 0);
        checkOutput("reset wr_data", wr_data, 0);
        checkOutput("reset flag_z", flag_z, 0);
        checkOutput("reset flag_c", flag_c, 0);
        checkOutput("reset wb_count", wb_count, 0);
        checkOutput("reset in_ready", in_ready, 1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].fl, vecs[i].op, vecs[i].rd,
                          vecs[i].wb, vecs[i].res, vecs[i].z, vecs[i].c);
            #1;
            checkOutput($sformatf("row%0d wr_en", i), wr_en, vecs[i].e_en);
            checkOutput($sformatf("row%0d wr_addr", i), wr_addr, vecs[i].e_addr);
            checkOutput($sformatf("row%0d wr_data", i), wr_data, vecs[i].e_data);
            checkOutput($sformatf("row%0d in_ready", i), in_ready, vecs[i].e_ready);
            checkOutput($sformatf("row%0d flag_z", i), flag_z, vecs[i].e_fz);
            checkOutput($sformatf("row%0d flag_c", i), flag_c, vecs[i].e_fc);
            checkOutput($sformatf("row%0d wb_count", i), wb_count, vecs[i].e_cnt);
        end

        // --- Asynchronous reset in the middle of a WR_LO cycle --------------
        applyStimulus(1, 0, OP_ADD, 12, 1, 64'h1234, 0, 1);
        applyStimulus(0, 0, OP_ADD, 0, 0, 64'h0, 0, 0);
        #1;
        checkOutput("pre-reset wr_en", wr_en, 1);
        checkOutput("pre-reset wr_addr", wr_addr, 12);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset wr_en", wr_en, 0);
        checkOutput("midreset wr_addr", wr_addr, 0);
        checkOutput("midreset wr_data", wr_data, 0);
        checkOutput("midreset flag_z", flag_z, 0);
        checkOutput("midreset flag_c", flag_c, 0);
        checkOutput("midreset wb_count", wb_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready", in_ready, 1);

        // --- Randomized run against the slot-queue model ---------------------
        resetDut();
        q.delete();
        m_last_addr = '0; m_last_data = '0; m_fz = 1'b0; m_fc = 1'b0; m_cnt = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0),
                          ops[$urandom_range(0, 9)],
                          5'($urandom_range(0, 31)),
                          ($urandom_range(0, 7) != 0),
                          {$urandom(), $urandom()},
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));

            // Expected outputs for this cycle, from the slot at the head.
            e_ready = !flush && !(q.size() > 0 && q[0].is_lo && q[0].is_mul);
            if (q.size() > 0) begin
                e_addr = q[0].addr;
                e_data = q[0].data;
                e_en   = q[0].wb && (q[0].addr != 5'd0) && !flush;
            end else begin
                e_addr = m_last_addr;
                e_data = m_last_data;
                e_en   = 1'b0;
            end

            #1;
            checkOutput($sformatf("rand%0d wr_en", cyc), wr_en, e_en);
            checkOutput($sformatf("rand%0d wr_addr", cyc), wr_addr, e_addr);
            checkOutput($sformatf("rand%0d wr_data", cyc), wr_data, e_data);
            checkOutput($sformatf("rand%0d in_ready", cyc), in_ready, e_ready);
            checkOutput($sformatf("rand%0d flag_z", cyc), flag_z, m_fz);
            checkOutput($sformatf("rand%0d flag_c", cyc), flag_c, m_fc);
            checkOutput($sformatf("rand%0d wb_count", cyc), wb_count, m_cnt);

            @(posedge clk);

            // Retire the head slot and enqueue whatever was accepted.
            if (q.size() > 0) begin
                m_last_addr = q[0].addr;
                m_last_data = q[0].data;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0) begin
                    h = q.pop_front();
                    if (e_en) m_cnt = m_cnt + 32'd1;
                    if (h.is_lo) begin
                        m_fz = h.z;
                        if (carryOp(h.op)) m_fc = h.c;
                    end
                end
                if (in_valid && e_ready) begin
                    s.addr   = in_rd;
                    s.data   = in_result[31:0];
                    s.wb     = in_wb_en;
                    s.is_lo  = 1'b1;
                    s.is_mul = (in_opcode == OP_MUL);
                    s.op     = in_opcode;
                    s.z      = in_z_flag;
                    s.c      = in_carry_flag;
                    q.push_back(s);
                    if (in_opcode == OP_MUL) begin
                        s.addr  = 5'((32'(in_rd) + 1) % 32);
                        s.data  = in_result[63:32];
                        s.is_lo = 1'b0;
                        q.push_back(s);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
